sar_search_4bit: RTL and testbench

- Successive-approximation controller that sits on the other side of comparator_4bit.
- It drives the comparator's B input with trial codes and reads back A_greater/A_equal/A_less.
- From these it recovers the unknown value on the comparator's A input, one bit per clock.
- Use: value acquisition, and closed-loop self-check of the comparator in the same design.

---
 rtl/sar_search_4bit.sv | 136 +++++++++++++
 tb/tb_sar_search_4bit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sar_search_4bit.sv
// Successive-approximation controller driving a magnitude comparator's B input.
// Resolves one bit of the comparator's A operand per clock, with early exit on equality.
module sar_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_greater,
  input  logic             cmp_equal,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] TOP_W   = ONE_W << (WIDTH-1);
  localparam logic [KW-1:0]    ZERO_K  = {KW{1'b0}};
  localparam logic [KW-1:0]    ONE_K   = KW'(1);
  localparam logic [KW-1:0]    TOP_K   = KW'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_trial;
  logic [KW-1:0]    r_bit;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_exact;
  logic             r_err;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_resolved;
  logic             w_onehot;

  assign w_mask = ONE_W << r_bit;

  // Flag sanity and the trial with the current bit decided by the comparator.
  always_comb begin
    w_onehot   = 1'b0;
    w_resolved = r_trial;
    case ({cmp_greater, cmp_equal, cmp_less})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase
    if (cmp_less) begin
      w_resolved = r_trial & ~w_mask;
    end else begin
      w_resolved = r_trial;
    end
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_trial  <= ZERO_W;
      r_bit    <= ZERO_K;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= ZERO_W;
      r_exact  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_SEARCH;
            r_trial <= TOP_W;
            r_bit   <= TOP_K;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_trial <= ZERO_W;
            r_busy  <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (!w_onehot || cmp_equal || (r_bit == ZERO_K)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_trial <= ZERO_W;
            if (!w_onehot) begin
              r_result <= r_trial;
              r_exact  <= 1'b0;
              r_err    <= 1'b1;
            end else if (cmp_equal) begin
              r_result <= r_trial;
              r_exact  <= 1'b1;
            end else begin
              r_result <= w_resolved;
              r_exact  <= 1'b0;
            end
          end else begin
            // Bit k is settled; tentatively set the next lower bit.
            r_trial <= w_resolved | (w_mask >> 1);
            r_bit   <= r_bit - ONE_K;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_trial <= ZERO_W;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_trial <= ZERO_W;
        end
      endcase
    end
  end

  assign trial  = r_trial;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign exact  = r_exact;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Self-checking bench for sar_search_4bit: vector table, corner sequences,
// exhaustive and random sweeps against an arithmetic binary-search model.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cmp_greater, cmp_equal, cmp_less;
  logic [3:0] trial, result;
  logic       busy, done, exact, err;

  logic [3:0] tb_a = 4'd0;
  logic       f_gl = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural comparator, with an injectable non-one-hot fault.
  always_comb begin
    cmp_greater = (tb_a > trial) | f_gl;
    cmp_equal   = (tb_a == trial) & ~f_gl;
    cmp_less    = (tb_a < trial) | f_gl;
  end

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .exact(exact), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Trial code at search step i: bits above k copied from A, bit k set, rest clear.
  function automatic logic [3:0] model_trial(input logic [3:0] a, input int i);
    int k, v;
    k = 3 - i;
    v = a;
    v = ((v >> (k + 1)) << (k + 1)) | (1 << k);
    return v[3:0];
  endfunction

  function automatic int model_n(input logic [3:0] a);
    for (int i = 0; i < 4; i++) begin
      if (model_trial(a, i) == a) return i + 1;
    end
    return 4;
  endfunction

  // One complete search from IDLE; fault_step < 0 means a healthy comparator.
  task automatic run(input logic [3:0] a, input int fault_step, input bit ign,
                     input logic [3:0] e_res, input bit e_ex, input bit e_err, input int e_n);
    tb_a  = a;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < e_n; i++) begin
      check("busy_search", busy, 1'b1);
      check("done_search", done, 1'b0);
      check("trial_seq", trial, model_trial(a, i));
      f_gl  = (i == fault_step);
      start = ign && (i == 1);
      step();
      f_gl  = 1'b0;
      start = 1'b0;
    end
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("trial_done", trial, 4'd0);
    check("result", result, e_res);
    check("exact", exact, e_ex);
    check("err", err, e_err);
    start = ign;
    step();
    start = 1'b0;
    check("done_low", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("trial_idle", trial, 4'd0);
    check("result_hold", result, e_res);
  endtask

  typedef struct {
    logic [3:0] a;
    int         fault_step;
    bit         ign;
    logic [3:0] e_res;
    bit         e_ex;
    bit         e_err;
    int         e_n;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd5,  -1, 1'b0, 4'd5,  1'b1, 1'b0, 4};
    vecs[1] = '{4'd9,  -1, 1'b0, 4'd9,  1'b1, 1'b0, 4};
    vecs[2] = '{4'd8,  -1, 1'b0, 4'd8,  1'b1, 1'b0, 1};
    vecs[3] = '{4'd0,  -1, 1'b0, 4'd0,  1'b0, 1'b0, 4};
    vecs[4] = '{4'd15, -1, 1'b0, 4'd15, 1'b1, 1'b0, 4};
    vecs[5] = '{4'd12,  1, 1'b0, 4'd12, 1'b0, 1'b1, 2};
    vecs[6] = '{4'd12, -1, 1'b0, 4'd12, 1'b1, 1'b0, 2};
    vecs[7] = '{4'd6,  -1, 1'b1, 4'd6,  1'b1, 1'b0, 3};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_trial", trial, 4'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 4'd0);
      check("rst_flags", {exact, err}, 2'b00);
    end

    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].fault_step, vecs[i].ign,
          vecs[i].e_res, vecs[i].e_ex, vecs[i].e_err, vecs[i].e_n);
    end

    // Reset mid-search abandons it without a done pulse.
    tb_a  = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_trial", trial, 4'd0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_done", {busy, done}, 2'b00);
    end

    for (int a = 0; a < 16; a++) begin
      run(a[3:0], -1, 1'b0, a[3:0], (a != 0), 1'b0, model_n(a[3:0]));
    end

    for (int r = 0; r < 24; r++) begin
      logic [3:0] ra;
      int         fs;
      ra = 4'($urandom_range(0, 15));
      fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, model_n(ra) - 1)) : -1;
      if (fs >= 0) begin
        run(ra, fs, 1'b0, model_trial(ra, fs), 1'b0, 1'b1, fs + 1);
      end else begin
        run(ra, -1, r[0], ra, (ra != 4'd0), 1'b0, model_n(ra));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
